key_ctrl_multi: RTL and testbench
=================================

# key_ctrl_multi

Parametrised multi-channel key front end: synchronises, debounces and classifies N mechanical key inputs. Produces a debounced level, single-cycle press/release/long-press strobes, and a press-toggled state bit per key. It replaces the single-key `key_state` logic and feeds the acquisition/transmit control FSM, with one toggle bit per control key such as start/stop capture.

## Interface
- `NUM_KEYS`, 4: number of independent key channels (≥1).
- `DEBOUNCE_CYC`, 1_000_000: stable cycles required to accept a level change (20 ms at 50 MHz, ≥2).
- `LONG_CYC`, 50_000_000: held cycles, counted from entry to HELD, before the long-press strobe fires (1 s at 50 MHz, >`DEBOUNCE_CYC`).
- `ACTIVE_HIGH`, 1: 1 means a pressed key reads 1; 0 means a pressed key reads 0.
- `clk` in 1: system clock. All logic is on this clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_in` in NUM_KEYS: raw asynchronous key pins.
- `key_level` out NUM_KEYS: debounced pressed level, 1 = pressed, independent of `ACTIVE_HIGH`.
- `key_press` out NUM_KEYS: one-cycle strobe on an accepted press.
- `key_release` out NUM_KEYS: one-cycle strobe on an accepted release.
- `key_long` out NUM_KEYS: one-cycle strobe when a held key reaches `LONG_CYC`.
- `key_toggle` out NUM_KEYS: flips on every accepted press.

## Operation
- Each channel is independent. Channels share no state.
- Input path: 2-FF synchroniser, then normalise so that s=1 means pressed. The synchroniser resets to the inactive pin level.
- Per-channel FSM: IDLE, PRESS_DEB, HELD, RELEASE_DEB.
  - IDLE, s=1: go to PRESS_DEB, cnt←0.
  - PRESS_DEB, s=1: cnt++. When cnt==DEBOUNCE_CYC-1, go to HELD, cnt←0. If s=0 at any point, return to IDLE with no strobe (bounce rejected).
  - HELD, s=1: cnt++, saturating at LONG_CYC-1. `key_long` fires once, in the cycle cnt first reaches LONG_CYC-1.
  - HELD, s=0: go to RELEASE_DEB, cnt←0.
  - RELEASE_DEB, s=0: cnt++. When cnt==DEBOUNCE_CYC-1, go to IDLE. If s=1, return to HELD and keep the saturated long status, so no second `key_long` fires.
- Counter width is $clog2(LONG_CYC). One counter per channel is shared by all states.
- `key_level` is 1 in HELD and RELEASE_DEB.
- `key_press` and `key_toggle` update on the transition PRESS_DEB→HELD.
- `key_release` fires on the transition RELEASE_DEB→IDLE.
- A press and a release on different channels in the same cycle are each reported on their own bit.
- Reset mid-operation: every FSM returns to IDLE, counters clear, and any in-progress press is discarded.

## Timing
- Reset values: `key_level`=0, `key_press`=0, `key_release`=0, `key_long`=0, `key_toggle`=0.
- All outputs are registered. Strobes are exactly one cycle wide.
- Press latency: `key_press` is high DEBOUNCE_CYC+3 rising edges after the first edge that samples a stable pressed pin. This is 2 synchroniser edges, plus 1 edge to enter PRESS_DEB, plus DEBOUNCE_CYC edges.
- Release latency: identical, DEBOUNCE_CYC+3 edges.
- `key_toggle` and `key_level` change in the same cycle as `key_press` goes high.
- `key_long` fires LONG_CYC cycles after `key_press`.
- A glitch shorter than DEBOUNCE_CYC cycles produces no output change.

## Configuration
- Macro: `KEY_LONG_PRESS_EN`.
- Defined: long-press counting and `key_long` behave as described above.
- Undefined: `key_long` is tied to 0 and the HELD counter is not incremented.
  - Counter width shrinks to $clog2(DEBOUNCE_CYC).
  - `LONG_CYC` is ignored.
  - All other behaviour is unchanged.

## Structure
- Package `key_pkg` holds:
  - the FSM state typedef (IDLE, PRESS_DEB, HELD, RELEASE_DEB);
  - a `KEY_SYNC_STAGES`=2 constant;
  - a function returning counter width from `DEBOUNCE_CYC`/`LONG_CYC`.
- Sub-module `key_debounce_ch`: one channel containing synchroniser, FSM and counter. The top generates `NUM_KEYS` instances and concatenates their outputs.

## Test plan
All scenarios use NUM_KEYS=2, DEBOUNCE_CYC=8, LONG_CYC=32, ACTIVE_HIGH=1.

1. Key 0 held high from cycle 10 → `key_press[0]` high at cycle 21 only; `key_level[0]`=1 and `key_toggle[0]`=1 from cycle 21; `key_long[0]` pulses at cycle 53.
2. Key 0 pulsed high for 5 cycles (bounce) → no strobes; `key_level`, `key_toggle` remain 0.
3. Key 0 pressed for 20 cycles then released → one `key_press`; one `key_release` 11 cycles after the falling pin edge; no `key_long`.
4. Key 0 pressed/released twice → `key_toggle[0]` goes 0→1→0; keys 0 and 1 pressed in the same cycle → `key_press`=2'b11 in one cycle.
5. Assert `rst` in PRESS_DEB and in HELD → all outputs 0 immediately; the first press after reset takes the full 11 cycles.
6. Build without `KEY_LONG_PRESS_EN`, key held for 100 cycles → `key_long` stays 0; press/release timing identical to scenario 1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key front end.
// Contents: per-channel FSM state type, synchroniser depth, counter-width helper.
// Build option: KEY_LONG_PRESS_EN selects the wider counter used for long-press timing.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } key_state_e;

  localparam int KEY_SYNC_STAGES = 2;

  // The shared per-channel counter must reach LONG_CYC-1 when long-press
  // timing is built in, otherwise only DEBOUNCE_CYC-1. Never narrower than 1 bit.
  function automatic int key_cnt_width(input int debounce_cyc,
                                       input int long_cyc,
                                       input bit long_en);
    int w;
    w = long_en ? $clog2(long_cyc) : $clog2(debounce_cyc);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, polarity normalise, debounce/hold FSM, shared counter.
// Ports: clk/rst, raw pin key_i; registered level_o, press_o, release_o, long_o, toggle_o.
// Build option: KEY_LONG_PRESS_EN enables HELD counting and the long_o strobe.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic toggle_o
);

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int            CW      = key_cnt_width(DEBOUNCE_CYC, LONG_CYC, LONG_EN);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYC - 1);
  // Pin level that corresponds to "not pressed"; synchroniser powers up here
  // so reset never looks like a press.
  localparam logic          PIN_IDLE = ~ACTIVE_HIGH;

  logic [KEY_SYNC_STAGES-1:0] sync_q;
  logic                       s;

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          toggle_q, toggle_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {KEY_SYNC_STAGES{PIN_IDLE}};
    end else begin
      sync_q <= {sync_q[KEY_SYNC_STAGES-2:0], key_i};
    end
  end

  // s = 1 means pressed regardless of pin polarity.
  assign s = ACTIVE_HIGH ? sync_q[KEY_SYNC_STAGES-1] : ~sync_q[KEY_SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      toggle_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      toggle_q    <= toggle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    toggle_d    = toggle_q;

    case (state_q)
      IDLE: begin
        long_done_d = 1'b0;
        if (s) begin
          state_d = PRESS_DEB;
          cnt_d   = '0;
        end
      end

      PRESS_DEB: begin
        if (!s) begin
          // Bounce: drop back silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d  = HELD;
          cnt_d    = '0;
          press_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HELD: begin
        if (!s) begin
          state_d = RELEASE_DEB;
          cnt_d   = '0;
        end else begin
`ifdef KEY_LONG_PRESS_EN
          // Count saturates; the strobe fires once when the saturated value is
          // seen, and long_done survives a release bounce so it cannot refire.
          if (cnt_q != CW'(LONG_CYC - 1)) begin
            cnt_d = cnt_q + CW'(1);
          end else if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
`endif
        end
      end

      RELEASE_DEB: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == HELD) || (state_d == RELEASE_DEB);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign toggle_o  = toggle_q;

endmodule

// File: rtl/key_ctrl_multi.sv
// N-channel key front end: debounced level plus press/release/long strobes and a press toggle per key.
// Ports: clk, rst (async active-high), key_in[N]; key_level/key_press/key_release/key_long/key_toggle[N].
// Build option: KEY_LONG_PRESS_EN enables long-press detection; otherwise key_long is always 0.
module key_ctrl_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_toggle
);

  // Channels are fully independent; each bit of every output comes from its own instance.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_i    (key_in[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .long_o   (key_long[i]),
      .toggle_o (key_toggle[i])
    );
  end

endmodule

// File: tb/tb_key_ctrl_multi.sv
// Directed bench for key_ctrl_multi with NUM_KEYS=2, DEBOUNCE_CYC=8, LONG_CYC=32, active-high keys.
// Long-press expectations follow KEY_LONG_PRESS_EN.
module tb_key_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] key_level, key_press, key_release, key_long, key_toggle;

  int n_cmp = 0;
  int n_bad = 0;

  key_ctrl_multi #(
    .NUM_KEYS    (2),
    .DEBOUNCE_CYC(8),
    .LONG_CYC    (32),
    .ACTIVE_HIGH (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_toggle (key_toggle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 ns after the last one (drive and sample point).
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : main
    logic [1:0] acc;
    int np, nr, nl, rel_at;

    // Reset state
    rst    = 1'b1;
    key_in = 2'b00;
    #1;
    chk("rst_async_level", key_level, 2'b00);
    step(2);
    rst = 1'b0;
    chk("rst_level",   key_level,   2'b00);
    chk("rst_press",   key_press,   2'b00);
    chk("rst_release", key_release, 2'b00);
    chk("rst_long",    key_long,    2'b00);
    chk("rst_toggle",  key_toggle,  2'b00);

    // Bounce of 5 cycles is rejected
    acc    = 2'b00;
    key_in = 2'b01;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) key_in = 2'b00;
      step(1);
      acc = acc | key_press | key_release | key_long | key_level | key_toggle;
    end
    chk("bounce_no_output", acc, 2'b00);

    // Long hold on key 0: press on the 11th edge
    key_in = 2'b01;
    step(10);
    chk("p1_press_e10", key_press, 2'b00);
    chk("p1_level_e10", key_level, 2'b00);
    step(1);
    chk("p1_press_e11",  key_press,  2'b01);
    chk("p1_level_e11",  key_level,  2'b01);
    chk("p1_toggle_e11", key_toggle, 2'b01);
    step(1);
    chk("p1_press_e12", key_press, 2'b00);
    chk("p1_level_e12", key_level, 2'b01);
`ifdef KEY_LONG_PRESS_EN
    step(30);
    chk("p1_long_e42", key_long, 2'b00);
    step(1);
    chk("p1_long_e43", key_long, 2'b01);
    acc = 2'b00;
    for (int i = 0; i < 57; i++) begin
      step(1);
      acc = acc | key_long;
    end
    chk("p1_long_once", acc, 2'b00);
`else
    acc = 2'b00;
    for (int i = 0; i < 88; i++) begin
      step(1);
      acc = acc | key_long;
    end
    chk("p1_long_off", acc, 2'b00);
`endif
    // Release: strobe on the 11th edge after the falling pin
    key_in = 2'b00;
    step(10);
    chk("r1_release_e10", key_release, 2'b00);
    chk("r1_level_e10",   key_level,   2'b01);
    step(1);
    chk("r1_release_e11", key_release, 2'b01);
    chk("r1_level_e11",   key_level,   2'b00);
    chk("r1_toggle_keep", key_toggle,  2'b01);
    step(1);
    chk("r1_release_e12", key_release, 2'b00);

    // 20-cycle press then release: one press, one release, no long
    np = 0; nr = 0; nl = 0; rel_at = -1;
    key_in = 2'b01;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) key_in = 2'b00;
      step(1);
      if (key_press[0])   np++;
      if (key_long[0])    nl++;
      if (key_release[0]) begin
        nr++;
        rel_at = i;
      end
    end
    chk("s3_press_cnt",   np, 1);
    chk("s3_release_cnt", nr, 1);
    chk("s3_long_cnt",    nl, 0);
    chk("s3_release_at",  rel_at, 30);
    chk("s3_toggle",      key_toggle, 2'b00);

    // Both keys pressed in the same cycle
    key_in = 2'b11;
    step(10);
    chk("s4_press_e10", key_press, 2'b00);
    step(1);
    chk("s4_press_both",  key_press,  2'b11);
    chk("s4_toggle_both", key_toggle, 2'b11);
    key_in = 2'b00;
    step(11);
    chk("s4_release_both", key_release, 2'b11);
    step(1);
    chk("s4_release_end", key_release, 2'b00);

    // Reset during PRESS_DEB
    key_in = 2'b01;
    step(5);
    rst = 1'b1;
    #1;
    chk("s5a_outs", {key_level, key_press, key_release, key_long, key_toggle}, 10'd0);
    step(1);
    rst = 1'b0;
    step(10);
    chk("s5a_press_e10", key_press, 2'b00);
    step(1);
    chk("s5a_press_e11",  key_press,  2'b01);
    chk("s5a_toggle_e11", key_toggle, 2'b01);

    // Reset during HELD
    step(3);
    chk("s5b_level_pre", key_level, 2'b01);
    rst = 1'b1;
    #1;
    chk("s5b_outs", {key_level, key_press, key_release, key_long, key_toggle}, 10'd0);
    step(1);
    rst = 1'b0;
    step(10);
    chk("s5b_press_e10", key_press, 2'b00);
    step(1);
    chk("s5b_press_e11", key_press, 2'b01);
    key_in = 2'b00;
    step(15);
    chk("s5b_level_end", key_level, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
